// File: rtl/fp16_fma_arbiter.sv
// fp16_fma_arbiter: round-robin arbiter sharing one pipelined FP16 FMA between NREQ requesters.
module fp16_fma_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 4,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    input  logic [16*NREQ-1:0]   req_c,
    input  logic                 drain,
    output logic                 fma_in_valid,
    output logic [15:0]          fma_a,
    output logic [15:0]          fma_b,
    output logic [15:0]          fma_c,
    input  logic [15:0]          fma_out,
    input  logic                 fma_out_valid,
    output logic [NREQ-1:0]      resp_valid,
    output logic [15:0]          resp_data,
    output logic [IDW+1:0]       outstanding,
    output logic                 idle,
    output logic                 err
);
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] g;
    logic           gv;
    logic [LATENCY-1:0] tv;
    logic [IDW-1:0] tid [LATENCY];
    logic           retire;
    // Scan downward so the lowest offset from ptr overwrites and wins.
    always_comb begin
        gv = 1'b0;
        g  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr) + k) % NREQ] && !drain && !rst) begin
                gv = 1'b1;
                g  = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end
    assign req_ready    = gv ? (NREQ'(1) << g) : '0;
    assign fma_in_valid = gv;
    assign fma_a        = gv ? req_a[{g, 4'b0000} +: 16] : '0;
    assign fma_b        = gv ? req_b[{g, 4'b0000} +: 16] : '0;
    assign fma_c        = gv ? req_c[{g, 4'b0000} +: 16] : '0;
    assign retire       = tv[LATENCY-1];
    assign idle         = (outstanding == '0) && !gv;
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gv) begin
            ptr <= (int'(g) == NREQ - 1) ? '0 : g + IDW'(1);
        end
    end
    // Tag pipeline mirrors the FMA depth so the owner pops out with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            tv <= '0;
            for (int i = 0; i < LATENCY; i++) tid[i] <= '0;
        end else begin
            tv[0]  <= gv;
            tid[0] <= g;
            for (int i = 1; i < LATENCY; i++) begin
                tv[i]  <= tv[i-1];
                tid[i] <= tid[i-1];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid  <= '0;
            resp_data   <= '0;
            err         <= 1'b0;
            outstanding <= '0;
        end else begin
            resp_valid  <= (retire && fma_out_valid) ? (NREQ'(1) << tid[LATENCY-1]) : '0;
            resp_data   <= (retire && fma_out_valid) ? fma_out : resp_data;
            err         <= err | (retire != fma_out_valid);
            outstanding <= outstanding + (IDW+2)'(gv) - (IDW+2)'(retire);
        end
    end
endmodule

// File: tb/tb_fp16_fma_arbiter.sv
// tb_fp16_fma_arbiter: table-driven check of grant rotation, tagging, drain, reset and err.
module tb_fp16_fma_arbiter;
    localparam int N = 4;
    localparam int L = 4;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst, drain, inject;
    logic [N-1:0] req_valid, req_ready, resp_valid;
    logic [16*N-1:0] req_a, req_b, req_c;
    logic fma_in_valid, fma_out_valid, idle, err;
    logic [15:0] fma_a, fma_b, fma_c, fma_out, resp_data;
    logic [W+1:0] outstanding;
    logic [15:0] la [N];
    logic [15:0] lb [N];
    logic [15:0] lc [N];
    logic [L-1:0] mv;
    logic [15:0] md [L];

    always #5 clk = ~clk;

    fp16_fma_arbiter #(.NREQ(N), .LATENCY(L), .IDW(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .drain(drain),
        .fma_in_valid(fma_in_valid), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
        .fma_out(fma_out), .fma_out_valid(fma_out_valid),
        .resp_valid(resp_valid), .resp_data(resp_data), .outstanding(outstanding),
        .idle(idle), .err(err)
    );

    // Hand-computed FP16 results for the known triples; other lanes use a tagged stub value.
    function automatic logic [15:0] ref_fma(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        if (a == 16'h4000 && b == 16'h4200 && c == 16'hCF00) return 16'hCD80;
        if (a == 16'hC000 && b == 16'hC000 && c == 16'h4700) return 16'h4980;
        return a ^ b ^ c ^ 16'h5A5A;
    endfunction

    always_comb begin
        req_a = '0;
        req_b = '0;
        req_c = '0;
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = la[i];
            req_b[16*i +: 16] = lb[i];
            req_c[16*i +: 16] = lc[i];
        end
    end

    // Behavioural FMA: fixed LATENCY delay line, cleared by the shared reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mv <= '0;
        end else begin
            mv    <= {mv[L-2:0], fma_in_valid};
            md[0] <= ref_fma(fma_a, fma_b, fma_c);
            for (int i = 1; i < L; i++) md[i] <= md[i-1];
        end
    end
    assign fma_out_valid = mv[L-1] | inject;
    assign fma_out       = md[L-1];

    typedef struct {
        logic [N-1:0] v;
        logic         d;
        logic [N-1:0] r;
    } vec_t;

    vec_t tbl [$];
    logic [N-1:0] ev [1024];
    logic [15:0]  ed [1024];
    int gh [1024];
    int cyc = 0;
    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("resp_valid", resp_valid, ev[cyc]);
        if (ev[cyc] != '0) chk("resp_data", resp_data, ed[cyc]);
    endtask

    task automatic add(input logic [N-1:0] v, input logic d, input logic [N-1:0] r, input int reps);
        vec_t e;
        e.v = v;
        e.d = d;
        e.r = r;
        for (int i = 0; i < reps; i++) tbl.push_back(e);
    endtask

    initial begin
        int eo, gi;
        for (int i = 0; i < 1024; i++) begin
            ev[i] = '0;
            ed[i] = '0;
            gh[i] = 0;
        end
        la[0] = 16'h4000; lb[0] = 16'h4200; lc[0] = 16'hCF00;
        la[1] = 16'hC000; lb[1] = 16'hC000; lc[1] = 16'h4700;
        la[2] = 16'h4000; lb[2] = 16'h4200; lc[2] = 16'hCF00;
        la[3] = 16'h3C00; lb[3] = 16'h3800; lc[3] = 16'h1111;

        add(4'b0001, 1'b0, 4'b0001, 1);
        add(4'b0000, 1'b0, 4'b0000, 6);
        add(4'b0110, 1'b0, 4'b0010, 1);
        add(4'b0100, 1'b0, 4'b0100, 1);
        add(4'b0000, 1'b0, 4'b0000, 6);
        add(4'b1000, 1'b0, 4'b1000, 1);
        add(4'b0000, 1'b0, 4'b0000, 5);
        for (int r = 0; r < 3; r++) begin
            add(4'b1111, 1'b0, 4'b0001, 1);
            add(4'b1111, 1'b0, 4'b0010, 1);
            add(4'b1111, 1'b0, 4'b0100, 1);
            add(4'b1111, 1'b0, 4'b1000, 1);
        end
        add(4'b1111, 1'b0, 4'b0001, 1);
        add(4'b1111, 1'b0, 4'b0010, 1);
        add(4'b1111, 1'b0, 4'b0100, 1);
        add(4'b1111, 1'b1, 4'b0000, 6);

        rst = 1'b1; drain = 1'b0; inject = 1'b0; req_valid = '0;
        tick();
        tick();
        req_valid = 4'b1111;
        #1;
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_in_valid", fma_in_valid, 1'b0);
        tick();
        chk("rst_resp_data", resp_data, 16'h0000);
        chk("rst_err", err, 1'b0);
        chk("rst_outstanding", outstanding, 0);
        rst = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_idle", idle, 1'b1);

        foreach (tbl[i]) begin
            tick();
            req_valid = tbl[i].v;
            drain = tbl[i].d;
            #1;
            eo = gh[cyc-1] + gh[cyc-2] + gh[cyc-3] + gh[cyc-4];
            chk("req_ready", req_ready, tbl[i].r);
            chk("fma_in_valid", fma_in_valid, tbl[i].r != '0);
            chk("outstanding", outstanding, eo);
            chk("idle", idle, eo == 0 && tbl[i].r == '0);
            if (tbl[i].r != '0) begin
                gi = 0;
                for (int k = 0; k < N; k++) if (tbl[i].r[k]) gi = k;
                chk("fma_a", fma_a, la[gi]);
                chk("fma_c", fma_c, lc[gi]);
                gh[cyc] = 1;
                ev[cyc+L+1] = tbl[i].r;
                ed[cyc+L+1] = ref_fma(la[gi], lb[gi], lc[gi]);
            end
        end

        // Reset with two ops in flight: lane 3 then lane 0 (ptr is 3 here).
        tick();
        drain = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("mid_grant0", req_ready, 4'b1000);
        tick();
        #1;
        chk("mid_grant1", req_ready, 4'b0001);
        tick();
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("mid_rst_ready", req_ready, 4'b0000);
        tick();
        rst = 1'b0;
        chk("post_rst_outstanding", outstanding, 0);
        chk("post_rst_err", err, 1'b0);
        #1;
        chk("post_rst_ptr", req_ready, 4'b0001);
        req_valid = '0;
        for (int i = 0; i < 6; i++) tick();
        chk("post_rst_idle", idle, 1'b1);

        // Spurious FMA result with an empty tag pipeline.
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("err_set", err, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_hold", err, 1'b1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_clear", err, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fp16_fma_arbiter.md
Name: fp16_fma_arbiter

Overview:
Round-robin arbiter that shares one pipelined FP16FMA unit between NREQ requesters.
- Each requester presents an (a, b, c) FP16 operand triple under valid/ready.
- The arbiter issues at most one triple per cycle into the FMA and tracks the owner of each in-flight op in a tag pipeline.
- Each result is returned to its owner on a one-hot response strobe.
- Sits between the matrix/vector sequencers and the single FP16 FMA datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
LATENCY, 4, FMA cycles from in_valid to out_valid; must equal the instantiated FMA's pipeline depth
IDW, 2, requester id width; must satisfy 2^IDW >= NREQ

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_a  in  16*NREQ  flattened FP16 a operands; requester i uses bits [16i+15:16i]
req_b  in  16*NREQ  flattened FP16 b operands, same packing
req_c  in  16*NREQ  flattened FP16 c operands, same packing
drain  in  1  block new grants while high
fma_in_valid  out  1  issue strobe to FMA
fma_a  out  16  a operand of granted requester
fma_b  out  16  b operand of granted requester
fma_c  out  16  c operand of granted requester
fma_out  in  16  FMA result
fma_out_valid  in  1  FMA result strobe
resp_valid  out  NREQ  one-hot result strobe, registered
resp_data  out  16  result, registered, shared by all requesters
outstanding  out  IDW+2  ops in flight, range 0..LATENCY
idle  out  1  high when outstanding==0 and no grant this cycle
err  out  1  sticky tag/out_valid mismatch flag

Behaviour:
- Reset values (sync, rst high at posedge):
  - ptr=0, tag pipeline cleared, outstanding=0.
  - resp_valid=0, resp_data=0, err=0.
  - While rst is high: req_ready=0 and fma_in_valid=0.
- Grant (combinational):
  - Scan requesters from ptr upward, wrapping modulo NREQ; the first with req_valid high is granted.
  - No grant when drain=1 or rst=1.
  - req_ready = one-hot of the grant; fma_in_valid = |grant.
  - fma_a/b/c = granted lanes; when there is no grant they hold 0.
- Pointer: on a grant to requester g, ptr <= (g+1) mod NREQ. Without a grant, ptr holds.
- Fairness: continuously valid requesters are served strictly in rotation. A requester waits at most NREQ-1 cycles.
- Tag pipeline:
  - LATENCY stages of {valid, id}; stage 0 loads {fma_in_valid, g}, and entries shift every cycle.
  - At the last stage, if stage_valid != fma_out_valid, set err (sticky until rst).
- Response (registered):
  - When the last stage is valid and fma_out_valid is high: resp_valid <= one-hot(id) and resp_data <= fma_out. Otherwise resp_valid <= 0.
  - resp_data holds its last value when no result is returned.
  - Accept-to-resp_valid latency = LATENCY+1 cycles.
  - Responses have no backpressure; requesters always sink them.
- outstanding: increments on issue and decrements on retire (last tag stage valid).
  - A simultaneous issue and retire leaves it unchanged.
  - It never exceeds LATENCY, since the FMA is fully pipelined.
- drain:
  - Grants stop in the same cycle that drain rises; ops already in flight complete normally.
  - idle rises once the last op has retired.
- Reset mid-operation: all in-flight tags are discarded and no resp_valid is produced for them. The FMA shares rst.
- Out-of-range requester lanes (NREQ < 2^IDW) are never granted.

Test Plan:
- Single op: requester 0 sends a=0x4000 (2.0), b=0x4200 (3.0), c=0xCF00 (-28.0).
  -> req_ready[0]=1 for 1 cycle; resp_valid=0001 and resp_data=0xCD80 (-22.0) exactly 5 cycles later.
- Two requesters in the same cycle:
  - req1 sends a=0xC000, b=0xC000, c=0x4700 ((-2)(-2)+7); req2 sends the 2*3-28 triple.
  - With ptr=0, req1 is granted first and req2 the next cycle.
  - -> resp 0010/0x4980 (11.0), then 0100/0xCD80 on consecutive cycles.
- All 4 requesters valid continuously for 12 cycles:
  - -> grants rotate 0,1,2,3,0,...; each requester gets exactly 3 grants; outstanding saturates at 4.
  - -> 12 responses with ids matching issue order.
- drain asserted while 3 ops are in flight:
  - -> no further req_ready; all 3 responses arrive; idle=1 the cycle after the last retire.
- rst asserted for 1 cycle with 2 ops in flight:
  - -> no resp_valid for those ops; outstanding=0, ptr=0, err=0 afterwards.
- Inject fma_out_valid=1 with an empty tag pipeline:
  - -> err=1 the next cycle, held until rst; no resp_valid.
